// File: rtl/switch_cell_writer_pkg.sv
// Shared sizes and FSM state encoding for the switch-driven frame-buffer cell writer.
// Pure declarations: no latency, no backpressure.
package cell_writer_pkg;
  localparam int AW     = 3;
  localparam int DW     = 3;
  localparam int NCELLS = 1 << AW;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    WRITE = 2'd2
  } state_t;
endpackage

// File: rtl/switch_cell_writer_sw_debounce.sv
// One switch: 2-flop synchroniser, plus a stability filter when SWITCH_CELL_WRITER_DEBOUNCE_EN is defined.
// Latency: 2 cycles, plus DEB_CYCLES with the filter; no backpressure.
module sw_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic sw_filt
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[0], sw};
  end

`ifdef SWITCH_CELL_WRITER_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      sw_filt <= 1'b0;
    end else if (sync_q[1] == sw_filt) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      sw_filt <= sync_q[1];
      cnt     <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  // DEB_CYCLES has no effect without the stability filter.
  localparam int unused_deb_cycles = DEB_CYCLES;
  assign sw_filt = sync_q[1];
`endif

endmodule

// File: rtl/switch_cell_writer.sv
// Clears the frame buffer after reset, then bumps a cell's colour on each filtered switch toggle (debounce: SWITCH_CELL_WRITER_DEBOUNCE_EN).
// Latency: write 2 cycles after a filtered toggle; at most one write per 2 cycles, toggles queue in pending.
module switch_cell_writer
  import cell_writer_pkg::*;
#(
  parameter int AW         = cell_writer_pkg::AW,
  parameter int DW         = cell_writer_pkg::DW,
  parameter int DEB_CYCLES = 250000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [(1<<AW)-1:0]   sw,
  output logic [AW-1:0]        mem_px_addr,
  output logic [DW-1:0]        mem_px_data,
  output logic                 px_wr,
  output logic                 init_done
);

  localparam int NCELLS = 1 << AW;

  state_t              state, state_nxt;
  logic [AW-1:0]       init_addr, init_addr_nxt;
  logic [AW-1:0]       rr_ptr, grant, idx;
  logic                grant_vld, take;
  logic [NCELLS-1:0]   filt, filt_q, pending, served;
  logic [DW-1:0]       color [NCELLS];
  logic                wr_nxt;
  logic [AW-1:0]       addr_nxt;
  logic [DW-1:0]       data_nxt;

  for (genvar i = 0; i < NCELLS; i++) begin : g_sw
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .sw      (sw[i]),
      .sw_filt (filt[i])
    );
  end

  always_comb begin
    state_nxt     = state;
    init_addr_nxt = init_addr;
    wr_nxt        = 1'b0;
    addr_nxt      = mem_px_addr;
    data_nxt      = mem_px_data;
    served        = '0;
    take          = 1'b0;
    grant         = '0;
    grant_vld     = 1'b0;
    idx           = '0;

    // Round-robin: first pending cell strictly after the last one served.
    for (int k = 1; k <= NCELLS; k++) begin
      idx = rr_ptr + AW'(k);
      if (!grant_vld && pending[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end

    case (state)
      INIT: begin
        wr_nxt        = 1'b1;
        addr_nxt      = init_addr;
        data_nxt      = '0;
        init_addr_nxt = init_addr + 1'b1;
        if (init_addr == AW'(NCELLS - 1)) state_nxt = IDLE;
      end
      IDLE: begin
        if (grant_vld) begin
          take          = 1'b1;
          wr_nxt        = 1'b1;
          addr_nxt      = grant;
          data_nxt      = color[grant] + 1'b1;
          served[grant] = 1'b1;
          state_nxt     = WRITE;
        end
      end
      WRITE:   state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= INIT;
      init_addr   <= '0;
      rr_ptr      <= '1;
      pending     <= '0;
      filt_q      <= '0;
      px_wr       <= 1'b0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      init_done   <= 1'b0;
      for (int i = 0; i < NCELLS; i++) color[i] <= '0;
    end else begin
      state       <= state_nxt;
      init_addr   <= init_addr_nxt;
      px_wr       <= wr_nxt;
      mem_px_addr <= addr_nxt;
      mem_px_data <= data_nxt;
      init_done   <= (state != INIT);
      filt_q      <= filt;
      // A toggle landing on the cycle its bit is served re-arms it.
      pending     <= (pending & ~served) | (filt ^ filt_q);
      if (take) begin
        color[grant] <= data_nxt;
        rr_ptr       <= grant;
      end
    end
  end

endmodule

// File: tb/tb_switch_cell_writer.sv
// Bench for switch_cell_writer: cycle-level reference model compared every cycle, plus directed literal checks.
module tb_switch_cell_writer;

  localparam int NC  = 8;
  localparam int DEB = 4;
`ifdef SWITCH_CELL_WRITER_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
`else
  localparam bit DEB_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NC-1:0] sw  = '0;
  logic [2:0]    mem_px_addr;
  logic [2:0]    mem_px_data;
  logic          px_wr;
  logic          init_done;

  int vectors     = 0;
  int miscompares = 0;

  switch_cell_writer #(.AW(3), .DW(3), .DEB_CYCLES(DEB)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .mem_px_addr (mem_px_addr),
    .mem_px_data (mem_px_data),
    .px_wr       (px_wr),
    .init_done   (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_n counts clock edges since reset release; the first NC edges are the
  // clear sequence, after which a grant may happen on any edge at least two
  // edges after the previous grant.
  logic [NC-1:0] m_s1, m_s2, m_f, m_fq, m_pend, m_tog;
  int            m_cnt   [NC];
  int            m_color [NC];
  int            m_ptr, m_n, m_last, m_g, m_idx;
  logic          e_wr, e_done;
  int            e_addr, e_data;

  function automatic void m_reset();
    m_s1 = '0; m_s2 = '0; m_f = '0; m_fq = '0; m_pend = '0;
    for (int i = 0; i < NC; i++) begin m_cnt[i] = 0; m_color[i] = 0; end
    m_ptr = NC - 1; m_n = 0; m_last = -100;
    e_wr = 1'b0; e_done = 1'b0; e_addr = 0; e_data = 0;
  endfunction

  initial m_reset();

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_reset();
    end else begin
      m_tog = m_f ^ m_fq;
      e_wr  = 1'b0;
      if (m_n < NC) begin
        e_wr = 1'b1; e_addr = m_n; e_data = 0;
      end else if ((m_n - m_last) >= 2 && m_pend != '0) begin
        m_g = -1;
        for (int k = 1; k <= NC; k++) begin
          m_idx = (m_ptr + k) % NC;
          if (m_g < 0 && m_pend[m_idx]) m_g = m_idx;
        end
        m_color[m_g] = (m_color[m_g] + 1) % 8;
        e_wr = 1'b1; e_addr = m_g; e_data = m_color[m_g];
        m_pend[m_g] = 1'b0;
        m_ptr = m_g; m_last = m_n;
      end
      e_done = (m_n >= NC);
      m_pend = m_pend | m_tog;
      m_fq   = m_f;
      if (DEB_ON) begin
        for (int i = 0; i < NC; i++) begin
          if (m_s2[i] != m_f[i]) begin
            m_cnt[i]++;
            if (m_cnt[i] == DEB) begin m_f[i] = m_s2[i]; m_cnt[i] = 0; end
          end else begin
            m_cnt[i] = 0;
          end
        end
        m_s2 = m_s1; m_s1 = sw;
      end else begin
        m_s2 = m_s1; m_s1 = sw; m_f = m_s2;
      end
      m_n++;
    end
  end

  always @(negedge clk) begin
    chk("px_wr",       px_wr,       e_wr);
    chk("mem_px_addr", mem_px_addr, e_addr);
    chk("mem_px_data", mem_px_data, e_data);
    chk("init_done",   init_done,   e_done);
  end

  // ---------------- directed helpers ----------------
  task automatic reset_init(input int tog_bit);
    #2 rst = 1'b0; sw = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < NC; i++) begin
      @(negedge clk);
      chk("init_wr",   px_wr,       1);
      chk("init_addr", mem_px_addr, i);
      chk("init_data", mem_px_data, 0);
      chk("init_done_low", init_done, 0);
      if (i == 2 && tog_bit >= 0) sw[tog_bit] = ~sw[tog_bit];
    end
    @(negedge clk);
    chk("init_done_high", init_done, 1);
    if (tog_bit >= 0) begin
      chk("post_init_wr",   px_wr,       1);
      chk("post_init_addr", mem_px_addr, tog_bit);
      chk("post_init_data", mem_px_data, 1);
    end else begin
      chk("post_init_idle", px_wr, 0);
    end
  endtask

  task automatic wait_write(input int limit, output int waited,
                            output logic [2:0] a, output logic [2:0] d);
    bit got;
    got = 1'b0; waited = 0; a = '0; d = '0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      waited++;
      if (px_wr) begin got = 1'b1; a = mem_px_addr; d = mem_px_data; end
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL wait_write: no write within %0d cycles", limit);
      waited = -1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         waited, nwr, b;
    logic [2:0] a, d;
    int         wd [8];

    // Clear sequence with a toggle during it, then reset while in WRITE.
    reset_init(5);
    #2 rst = 1'b0;
    #1;
    chk("rst_px_wr", px_wr, 0);
    chk("rst_addr",  mem_px_addr, 0);
    chk("rst_data",  mem_px_data, 0);
    chk("rst_done",  init_done, 0);

    // Eight toggles of one cell walk its colour 1..7 then wrap to 0.
    reset_init(-1);
    for (int k = 0; k < 8; k++) begin
      sw[3] = ~sw[3];
      wait_write(40, waited, a, d);
      if (k == 0) chk("toggle_latency", waited, DEB_ON ? 8 : 4);
      chk("walk_addr", a, 3);
      chk("walk_data", d, (k + 1) % 8);
      repeat (6) @(negedge clk);
    end

    // Simultaneous toggles: round-robin from pointer 7 serves 1 then 6.
    reset_init(-1);
    sw[1] = 1'b1; sw[6] = 1'b1;
    wait_write(40, waited, a, d);
    chk("rr_first_addr", a, 1);
    chk("rr_first_data", d, 1);
    wait_write(40, waited, a, d);
    chk("rr_gap", waited, 2);
    chk("rr_second_addr", a, 6);
    chk("rr_second_data", d, 1);

    // Bounce 0-1-0-1 with 2-cycle gaps, then hold 1.
    reset_init(-1);
    nwr = 0;
    for (int c = 0; c < 50; c++) begin
      if (c == 0) sw[0] = 1'b1;
      if (c == 2) sw[0] = 1'b0;
      if (c == 4) sw[0] = 1'b1;
      @(negedge clk);
      if (px_wr) begin
        chk("bounce_addr", mem_px_addr, 0);
        if (nwr < 8) wd[nwr] = int'(mem_px_data);
        nwr++;
      end
    end
    chk("bounce_writes", nwr, DEB_ON ? 1 : 3);
    chk("bounce_data0", wd[0], 1);
    if (!DEB_ON) begin
      chk("bounce_data1", wd[1], 2);
      chk("bounce_data2", wd[2], 3);
    end

    // Random toggling on all switches against the model, one reset midway.
    reset_init(-1);
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        b = int'($urandom_range(NC - 1));
        sw[b] = ~sw[b];
      end
      if (c == 1200) reset_init(-1);
    end
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
